// File: rtl/quadrature_encoder_gen.sv
// quadrature_encoder_gen: emulates a mechanical rotary encoder by turning
// step requests into a Gray-coded A/B quadrature waveform. It also keeps a
// wrapping count of the steps issued since reset.
// Each accepted step moves exactly one channel, then holds the new phase for
// DWELL clocks before the next request is accepted.
// Optional feature macro: QUAD_BOUNCE_EN. When it is defined, the channel that
// changed also chatters 2*BOUNCE_PULSES times, BOUNCE_LEN clocks apart, and
// settles on the new phase. This emulates contact bounce.
`timescale 1ns/1ps
module quadrature_encoder_gen #(
  parameter int DWELL         = 2048,
  parameter int COUNT_W       = 8,
  parameter int BOUNCE_PULSES = 3,
  parameter int BOUNCE_LEN    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic               step_ready,
  output logic               a,
  output logic               b,
  output logic [COUNT_W-1:0] position,
  output logic               busy
);

  localparam int DCNT_W = $clog2(DWELL);

  typedef enum logic {ST_IDLE, ST_DWELL} state_t;

  state_t             state_q, state_d;
  logic [DCNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]         ab_q, ab_d;
  logic [COUNT_W-1:0] pos_q, pos_d;

  // Reject parameter sets that cannot produce a well-formed waveform
  generate
    if (DWELL < 2) begin : g_dwell_chk
      $error("quadrature_encoder_gen: DWELL must be at least 2");
    end
`ifdef QUAD_BOUNCE_EN
    if (2 * BOUNCE_PULSES * BOUNCE_LEN >= DWELL) begin : g_bounce_chk
      $error("quadrature_encoder_gen: bounce train must finish inside the dwell");
    end
`else
    if (BOUNCE_PULSES < 0 || BOUNCE_LEN < 1) begin : g_bounce_chk
      $error("quadrature_encoder_gen: bounce parameters out of range");
    end
`endif
  endgenerate

`ifdef QUAD_BOUNCE_EN
  localparam int BL_W   = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
  localparam int LEFT_W = $clog2(2 * BOUNCE_PULSES + 1);

  logic [BL_W-1:0]   bTmr_q, bTmr_d;
  logic [LEFT_W-1:0] bLeft_q, bLeft_d;
  logic [1:0]        bMask_q, bMask_d;
`endif

  // State, phase, position and dwell timer registers; reset forces phase 00 at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ab_q    <= 2'b00;
      pos_q   <= '0;
`ifdef QUAD_BOUNCE_EN
      bTmr_q  <= '0;
      bLeft_q <= '0;
      bMask_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
`ifdef QUAD_BOUNCE_EN
      bTmr_q  <= bTmr_d;
      bLeft_q <= bLeft_d;
      bMask_q <= bMask_d;
`endif
    end
  end

  // Next state: accept a step in IDLE, advance the Gray phase, then time the dwell
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    pos_d   = pos_q;
`ifdef QUAD_BOUNCE_EN
    bTmr_d  = bTmr_q;
    bLeft_d = bLeft_q;
    bMask_d = bMask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (step_valid) begin
          ab_d    = step_dir ? {~ab_q[0], ab_q[1]} : {ab_q[0], ~ab_q[1]};
          pos_d   = step_dir ? pos_q + COUNT_W'(1) : pos_q - COUNT_W'(1);
          state_d = ST_DWELL;
          cnt_d   = '0;
`ifdef QUAD_BOUNCE_EN
          bMask_d = ab_d ^ ab_q;
          bTmr_d  = '0;
          bLeft_d = LEFT_W'(2 * BOUNCE_PULSES);
`endif
        end
      end
      ST_DWELL: begin
        if (cnt_q == DCNT_W'(DWELL - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DCNT_W'(1);
        end
`ifdef QUAD_BOUNCE_EN
        if (bLeft_q != '0) begin
          if (bTmr_q == BL_W'(BOUNCE_LEN - 1)) begin
            ab_d    = ab_q ^ bMask_q;
            bTmr_d  = '0;
            bLeft_d = bLeft_q - LEFT_W'(1);
          end else begin
            bTmr_d = bTmr_q + BL_W'(1);
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step_ready = (state_q == ST_IDLE);
  assign busy       = ~step_ready;
  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign position   = pos_q;

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Testbench for quadrature_encoder_gen with DWELL shortened to 8.
// A phase-index/position model in the bench is compared against the DUT on every
// clock. Directed sequences add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_quadrature_encoder_gen;

  localparam int DWELL   = 8;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               step_valid;
  logic               step_dir;
  logic               step_ready;
  logic               a;
  logic               b;
  logic [COUNT_W-1:0] position;
  logic               busy;

  int checks = 0;
  int errors = 0;
  bit modelOn = 1'b0;

  quadrature_encoder_gen #(.DWELL(DWELL), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_dir(step_dir),
    .step_ready(step_ready), .a(a), .b(b), .position(position), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: the phase is an index into the up-going Gray cycle.
  // The generator is ready once DWELL clocks have passed since the last accept.
  logic [1:0]         phaseTab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int                 mIdx;
  int                 mSince;
  logic [COUNT_W-1:0] mPos;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mIdx   = 0;
      mPos   = '0;
      mSince = DWELL;
    end else if (mSince >= DWELL && step_valid === 1'b1) begin
      mIdx   = step_dir ? (mIdx + 1) % 4 : (mIdx + 3) % 4;
      mPos   = step_dir ? mPos + 8'd1 : mPos - 8'd1;
      mSince = 0;
    end else if (mSince < DWELL) begin
      mSince = mSince + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every settled cycle against the model
  always @(negedge clk) begin
    if (!rst && modelOn) begin
      checkOutput("model_ab", {30'd0, a, b}, {30'd0, phaseTab[mIdx]});
      checkOutput("model_position", {24'd0, position}, {24'd0, mPos});
      checkOutput("model_ready", {31'd0, step_ready}, {31'd0, (mSince >= DWELL)});
      checkOutput("model_busy", {31'd0, busy}, {31'd0, (mSince < DWELL)});
    end
  end

  // One step: wait for ready (bounded), request for one clock, then time the dwell.
  task automatic applyStimulus(input logic dir, output logic [1:0] abSeen);
    int w = 0;
    int lowCnt = 0;
    while (step_ready !== 1'b1 && w < DWELL + 4) begin
      @(negedge clk);
      w++;
    end
    if (step_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: step_ready=%b, expected 1", step_ready);
    end
    step_valid = 1'b1;
    step_dir   = dir;
    @(negedge clk);
    step_valid = 1'b0;
    step_dir   = ~dir;
    abSeen = {a, b};
    while (step_ready === 1'b0 && lowCnt < DWELL + 4) begin
      lowCnt++;
      @(negedge clk);
    end
    checkOutput("dwell_low_cycles", lowCnt, DWELL);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] seen;
    logic [1:0] upExp [4]   = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] downExp [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int         holdExp [5] = '{0, 9, 18, 27, 36};
    int         changes [$];
    logic [COUNT_W-1:0] prevPos;
    logic [COUNT_W-1:0] pos255;

    rst = 1'b1;
    step_valid = 1'b0;
    step_dir = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ab", {a, b}, 2'b00);
    checkOutput("reset_position", position, 8'h00);
    checkOutput("reset_ready", step_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b0;
    modelOn = 1'b1;
    @(negedge clk);

    // Four up steps walk the Gray cycle forwards
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, seen);
      checkOutput("up_phase", seen, upExp[i]);
    end
    checkOutput("up_position", position, 8'h04);

    // Start a step, then reset asynchronously in the middle of the dwell
    step_valid = 1'b1;
    step_dir   = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_before_reset", busy, 1'b1);
    checkOutput("ab_before_reset", {a, b}, 2'b10);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_ab", {a, b}, 2'b00);
    checkOutput("async_reset_position", position, 8'h00);
    checkOutput("async_reset_ready", step_ready, 1'b1);
    checkOutput("async_reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Four down steps from reset walk the cycle backwards
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, seen);
      checkOutput("down_phase", seen, downExp[i]);
    end
    checkOutput("down_position", position, 8'hFC);

    // Up then down returns to the prior phase and position
    applyStimulus(1'b1, seen);
    checkOutput("updown_phase1", seen, 2'b10);
    applyStimulus(1'b0, seen);
    checkOutput("updown_phase2", seen, 2'b00);
    checkOutput("updown_position", position, 8'hFC);

    // step_valid held high for 40 clocks: accepts every DWELL+1 clocks
    doReset();
    prevPos = position;
    step_valid = 1'b1;
    step_dir   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (position !== prevPos) changes.push_back(i);
      prevPos = position;
    end
    step_valid = 1'b0;
    checkOutput("hold_accept_count", changes.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < changes.size()) checkOutput("hold_accept_clock", changes[i], holdExp[i]);
    end
    checkOutput("hold_position", position, 8'h05);
    checkOutput("hold_ab", {a, b}, 2'b10);

    // Direction toggling every clock while requesting; only the accept edge matters
    for (int i = 0; i < 20; i++) begin
      step_valid = 1'b1;
      step_dir   = i[0];
      @(negedge clk);
    end
    step_valid = 1'b0;

    // 256 up steps wrap the position through 0xFF -> 0x00
    doReset();
    pos255 = '0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, seen);
      if (i == 254) pos255 = position;
    end
    checkOutput("wrap_pos_255", pos255, 8'hFF);
    checkOutput("wrap_pos_256", position, 8'h00);
    checkOutput("wrap_ab", {a, b}, 2'b00);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
